warface_cpu_regs: RTL

WARFACE_CPU_REGS -- requirements
Module: warface_cpu_regs

---
 rtl/warface_cpu_regs.sv | 138 +++++++++++++
 1 files changed

// File: rtl/warface_cpu_regs.sv
// Warface mapper CPU-side registers: PRG/CHR bank select and a 14-bit one-shot IRQ timer.
// Optional macro WARFACE_IRQ_RELOAD_EN adds an auto-reload flag (reg3 bit 6) to the IRQ timer.
module warface_cpu_regs (
  input  logic       m2,
  input  logic       reset,
  input  logic       romsel,
  input  logic       cpu_rw,
  input  logic       cpu_a14,
  input  logic       cpu_a13,
  input  logic       cpu_a1,
  input  logic       cpu_a0,
  input  logic [7:0] cpu_data,
  output logic [2:0] prg_bank,
  output logic [4:0] chr_bank,
  output logic       prg_auto_switch,
  output logic       irq_pending,
  output wire        irq
);

  localparam int unsigned PRG_W = 3;
  localparam int unsigned CHR_W = 5;
  localparam int unsigned CNT_W = 14;

  typedef enum logic {IDLE, COUNT} state_t;

  state_t             state_q, state_d;
  logic [PRG_W-1:0]   prg_bank_q, prg_bank_d;
  logic [CHR_W-1:0]   chr_bank_q, chr_bank_d;
  logic               auto_sw_q, auto_sw_d;
  logic [CNT_W-1:0]   latch_q, latch_d;
  logic [CNT_W-1:0]   counter_q, counter_d;
  logic               irq_pending_q, irq_pending_d;
  logic               reg_wr_c;
  logic               fire_c;
  logic [1:0]         reg_idx_c;
  logic [CNT_W-1:0]   start_val_c;
`ifdef WARFACE_IRQ_RELOAD_EN
  logic               reload_q, reload_d;
`else
  logic               unused_data6;
  assign unused_data6 = cpu_data[6];
`endif

  // Next-state: timer tick first, then register writes, then reset overrides everything.
  always_comb begin
    state_d       = state_q;
    prg_bank_d    = prg_bank_q;
    chr_bank_d    = chr_bank_q;
    auto_sw_d     = auto_sw_q;
    latch_d       = latch_q;
    counter_d     = counter_q;
    irq_pending_d = irq_pending_q;
`ifdef WARFACE_IRQ_RELOAD_EN
    reload_d      = reload_q;
`endif
    reg_wr_c    = romsel & ~cpu_rw & cpu_a14 & cpu_a13;
    reg_idx_c   = {cpu_a1, cpu_a0};
    start_val_c = {cpu_data[5:0], latch_q[7:0]};
    fire_c      = (state_q == COUNT) && (counter_q == CNT_W'(1));

    if (state_q == COUNT) begin
      counter_d = counter_q - CNT_W'(1);
    end
    if (fire_c) begin
      irq_pending_d = 1'b1;
      state_d       = IDLE;
`ifdef WARFACE_IRQ_RELOAD_EN
      // A zero latch cannot be reloaded; the timer stops instead of wrapping.
      if (reload_q && (latch_q != '0)) begin
        counter_d = latch_q;
        state_d   = COUNT;
      end
`endif
    end

    if (reg_wr_c) begin
      unique case (reg_idx_c)
        2'd0: begin
          prg_bank_d = cpu_data[PRG_W-1:0];
          if (!fire_c) irq_pending_d = 1'b0;
        end
        2'd1: begin
          chr_bank_d = cpu_data[CHR_W-1:0];
          auto_sw_d  = cpu_data[7];
        end
        2'd2: latch_d[7:0] = cpu_data;
        2'd3: begin
          latch_d[13:8] = cpu_data[5:0];
`ifdef WARFACE_IRQ_RELOAD_EN
          reload_d = cpu_data[6];
`endif
          if (cpu_data[7]) begin
            counter_d = start_val_c;
            state_d   = (start_val_c != '0) ? COUNT : IDLE;
          end else begin
            counter_d = counter_q;
            state_d   = IDLE;
          end
        end
        default: ;
      endcase
    end

    if (reset) begin
      state_d       = IDLE;
      prg_bank_d    = '0;
      chr_bank_d    = '0;
      auto_sw_d     = 1'b0;
      latch_d       = '0;
      counter_d     = '0;
      irq_pending_d = 1'b0;
`ifdef WARFACE_IRQ_RELOAD_EN
      reload_d      = 1'b0;
`endif
    end
  end

  always_ff @(negedge m2) begin
    state_q       <= state_d;
    prg_bank_q    <= prg_bank_d;
    chr_bank_q    <= chr_bank_d;
    auto_sw_q     <= auto_sw_d;
    latch_q       <= latch_d;
    counter_q     <= counter_d;
    irq_pending_q <= irq_pending_d;
`ifdef WARFACE_IRQ_RELOAD_EN
    reload_q      <= reload_d;
`endif
  end

  assign prg_bank        = prg_bank_q;
  assign chr_bank        = chr_bank_q;
  assign prg_auto_switch = auto_sw_q;
  assign irq_pending     = irq_pending_q;
  // Open-drain /IRQ: only ever pulls low.
  assign irq             = irq_pending_q ? 1'b0 : 1'bz;

endmodule
